// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared ALU opcodes and EX-stage FSM encoding
package ex_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;
   localparam logic [2:0] ALU_SLL = 3'b101;
   localparam logic [2:0] ALU_MUL = 3'b110;
   localparam logic [2:0] ALU_SRL = 3'b111;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } ex_state_e;

endpackage

// File: rtl/ex_seq_mul.sv
// rtl/ex_seq_mul.sv - iterative shift-add multiplier, one partial product per cycle
module ex_seq_mul
   import ex_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int MUL_CYCLES = WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int CW = $clog2(MUL_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

   logic             busy_q, busy_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_step;

   // Accumulator value after the current step; on the last step this is the product.
   always_comb begin
      acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
   end

   // Next-state: abort beats everything, a running multiply ignores start.
   always_comb begin
      busy_d   = busy_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      if (abort) begin
         busy_d = 1'b0;
      end else if (busy_q) begin
         acc_d    = acc_step;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + 1'b1;
         if (cnt_q == LAST) begin
            busy_d = 1'b0;
         end
      end else if (start) begin
         busy_d   = 1'b1;
         cnt_d    = '0;
         acc_d    = '0;
         mcand_d  = a;
         mplier_d = b;
      end
   end

   // Multiplier state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q   <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else begin
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
      end
   end

   assign busy    = busy_q;
   assign done    = busy_q && (cnt_q == LAST);
   assign product = acc_step;

endmodule

// File: rtl/ex_alu_stage.sv
// rtl/ex_alu_stage.sv - EX stage: ALU, sequential MUL with upstream stall, EX/MEM register
module ex_alu_stage
   import ex_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int REGW       = 4,
   parameter int MUL_CYCLES = WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             regwrite,
   input  logic             memread,
   input  logic             memwrite,
   input  logic             branch,
   input  logic             memtoreg,
   input  logic             regdst,
   input  logic             alusrc,
   input  logic [WIDTH-1:0] data1,
   input  logic [WIDTH-1:0] data2,
   input  logic [WIDTH-1:0] offset,
   input  logic [REGW-1:0]  regdest1,
   input  logic [REGW-1:0]  regdest2,
   input  logic [2:0]       aluop,
   input  logic             flush,
   output logic             stall,
   output logic             regwriteout,
   output logic             memreadout,
   output logic             memwriteout,
   output logic             memtoregout,
   output logic             branchtaken,
   output logic [WIDTH-1:0] aluresult,
   output logic [WIDTH-1:0] storedata,
   output logic [REGW-1:0]  destreg,
   output logic             zero
);

   ex_state_e        state_q, state_d;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] alu_res;
   logic [REGW-1:0]  dest_sel;
   logic             mul_start, mul_abort, mul_busy, mul_done;
   logic [WIDTH-1:0] mul_product;

   // Control and store data captured when a MUL starts, replayed when it finishes.
   logic             lat_rw_q, lat_mr_q, lat_mw_q, lat_m2r_q, lat_br_q;
   logic [REGW-1:0]  lat_dest_q;
   logic [WIDTH-1:0] lat_store_q;

   logic             regwrite_q, memread_q, memwrite_q, memtoreg_q, branchtaken_q, zero_q;
   logic [WIDTH-1:0] aluresult_q, storedata_q;
   logic [REGW-1:0]  destreg_q;

   assign dest_sel = regdst ? regdest2 : regdest1;

   // Single-cycle ALU; MUL is produced by the sequential unit instead.
   always_comb begin
      opb     = alusrc ? offset : data2;
      alu_res = '0;
      case (aluop)
         ALU_ADD: alu_res = data1 + opb;
         ALU_SUB: alu_res = data1 - opb;
         ALU_AND: alu_res = data1 & opb;
         ALU_OR:  alu_res = data1 | opb;
         ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(data1) < $signed(opb))};
         ALU_SLL: alu_res = data1 << opb[3:0];
         ALU_SRL: alu_res = data1 >> opb[3:0];
         default: alu_res = '0;
      endcase
   end

   // FSM next state and stall: a flush always releases the pipeline that cycle.
   always_comb begin
      state_d   = state_q;
      stall     = 1'b0;
      mul_start = 1'b0;
      mul_abort = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (aluop == ALU_MUL && !flush) begin
               stall     = 1'b1;
               mul_start = 1'b1;
               state_d   = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (flush) begin
               mul_abort = 1'b1;
               state_d   = ST_IDLE;
            end else if (mul_done) begin
               state_d = ST_IDLE;
            end else begin
               stall = mul_busy;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      stall = stall & rst_n;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Capture MUL instruction context at the start edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_rw_q    <= 1'b0;
         lat_mr_q    <= 1'b0;
         lat_mw_q    <= 1'b0;
         lat_m2r_q   <= 1'b0;
         lat_br_q    <= 1'b0;
         lat_dest_q  <= '0;
         lat_store_q <= '0;
      end else if (mul_start) begin
         lat_rw_q    <= regwrite;
         lat_mr_q    <= memread;
         lat_mw_q    <= memwrite;
         lat_m2r_q   <= memtoreg;
         lat_br_q    <= branch;
         lat_dest_q  <= dest_sel;
         lat_store_q <= data2;
      end
   end

   ex_seq_mul #(
      .WIDTH      (WIDTH),
      .MUL_CYCLES (MUL_CYCLES)
   ) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .abort   (mul_abort),
      .a       (data1),
      .b       (opb),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   // EX/MEM register: bubbles clear control only; data holds or updates harmlessly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regwrite_q    <= 1'b0;
         memread_q     <= 1'b0;
         memwrite_q    <= 1'b0;
         memtoreg_q    <= 1'b0;
         branchtaken_q <= 1'b0;
         zero_q        <= 1'b0;
         aluresult_q   <= '0;
         storedata_q   <= '0;
         destreg_q     <= '0;
      end else if (state_q == ST_BUSY) begin
         if (flush || !mul_done) begin
            regwrite_q    <= 1'b0;
            memread_q     <= 1'b0;
            memwrite_q    <= 1'b0;
            memtoreg_q    <= 1'b0;
            branchtaken_q <= 1'b0;
         end else begin
            regwrite_q    <= lat_rw_q;
            memread_q     <= lat_mr_q;
            memwrite_q    <= lat_mw_q;
            memtoreg_q    <= lat_m2r_q;
            branchtaken_q <= lat_br_q && (mul_product == '0);
            zero_q        <= (mul_product == '0);
            aluresult_q   <= mul_product;
            storedata_q   <= lat_store_q;
            destreg_q     <= lat_dest_q;
         end
      end else if (flush) begin
         regwrite_q    <= 1'b0;
         memread_q     <= 1'b0;
         memwrite_q    <= 1'b0;
         memtoreg_q    <= 1'b0;
         branchtaken_q <= 1'b0;
         zero_q        <= (alu_res == '0);
         aluresult_q   <= alu_res;
         storedata_q   <= data2;
         destreg_q     <= dest_sel;
      end else if (aluop == ALU_MUL) begin
         regwrite_q    <= 1'b0;
         memread_q     <= 1'b0;
         memwrite_q    <= 1'b0;
         memtoreg_q    <= 1'b0;
         branchtaken_q <= 1'b0;
      end else begin
         regwrite_q    <= regwrite;
         memread_q     <= memread;
         memwrite_q    <= memwrite;
         memtoreg_q    <= memtoreg;
         branchtaken_q <= branch && (alu_res == '0);
         zero_q        <= (alu_res == '0);
         aluresult_q   <= alu_res;
         storedata_q   <= data2;
         destreg_q     <= dest_sel;
      end
   end

   assign regwriteout = regwrite_q;
   assign memreadout  = memread_q;
   assign memwriteout = memwrite_q;
   assign memtoregout = memtoreg_q;
   assign branchtaken = branchtaken_q;
   assign zero        = zero_q;
   assign aluresult   = aluresult_q;
   assign storedata   = storedata_q;
   assign destreg     = destreg_q;

endmodule

// File: tb/tb_ex_alu_stage.sv
// tb/tb_ex_alu_stage.sv - randomized self-checking bench for ex_alu_stage
module tb_ex_alu_stage;

   localparam int W  = 16;
   localparam int RW = 4;
   localparam int MC = 16;

   typedef struct {
      logic          rw, mr, mw, br, m2r, rdst, asrc;
      logic [W-1:0]  d1, d2, off;
      logic [RW-1:0] rt, rd;
      logic [2:0]    op;
   } instr_t;

   logic clk, rst_n;
   logic regwrite, memread, memwrite, branch, memtoreg, regdst, alusrc, flush;
   logic [W-1:0] data1, data2, offset;
   logic [RW-1:0] regdest1, regdest2;
   logic [2:0] aluop;
   logic stall, regwriteout, memreadout, memwriteout, memtoregout, branchtaken, zero;
   logic [W-1:0] aluresult, storedata;
   logic [RW-1:0] destreg;

   int n_vec = 0;
   int n_err = 0;

   ex_alu_stage #(.WIDTH(W), .REGW(RW), .MUL_CYCLES(MC)) dut (
      .clk(clk), .rst_n(rst_n),
      .regwrite(regwrite), .memread(memread), .memwrite(memwrite), .branch(branch),
      .memtoreg(memtoreg), .regdst(regdst), .alusrc(alusrc),
      .data1(data1), .data2(data2), .offset(offset),
      .regdest1(regdest1), .regdest2(regdest2), .aluop(aluop), .flush(flush),
      .stall(stall), .regwriteout(regwriteout), .memreadout(memreadout),
      .memwriteout(memwriteout), .memtoregout(memtoregout), .branchtaken(branchtaken),
      .aluresult(aluresult), .storedata(storedata), .destreg(destreg), .zero(zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference ALU built from plain integer arithmetic.
   function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      longint ua = longint'(a);
      longint ub = longint'(b);
      longint sa = (ua >= 32768) ? ua - 65536 : ua;
      longint sb = (ub >= 32768) ? ub - 65536 : ub;
      longint p2 = 1;
      longint r  = 0;
      for (int k = 0; k < int'(ub % 16); k++) p2 = p2 * 2;
      case (op)
         3'd0: r = (ua + ub) % 65536;
         3'd1: r = (ua - ub + 65536) % 65536;
         3'd2: r = longint'(a & b);
         3'd3: r = longint'(a | b);
         3'd4: r = (sa < sb) ? 1 : 0;
         3'd5: r = (ua * p2) % 65536;
         3'd6: r = (ua * ub) % 65536;
         default: r = ua / p2;
      endcase
      return r[W-1:0];
   endfunction

   function automatic instr_t rand_instr();
      instr_t i;
      i.rw = 1'($urandom); i.mr = 1'($urandom); i.mw = 1'($urandom);
      i.br = 1'($urandom); i.m2r = 1'($urandom); i.rdst = 1'($urandom);
      i.asrc = 1'($urandom);
      i.d1 = 16'($urandom); i.d2 = 16'($urandom); i.off = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
         i.d2 = i.d1;
         i.off = i.d1;
      end
      i.rt = 4'($urandom); i.rd = 4'($urandom);
      i.op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) i.op = 3'd6;
      return i;
   endfunction

   function automatic instr_t nop_instr();
      instr_t i;
      i.rw = 0; i.mr = 0; i.mw = 0; i.br = 0; i.m2r = 0; i.rdst = 0; i.asrc = 0;
      i.d1 = '0; i.d2 = '0; i.off = '0; i.rt = '0; i.rd = '0; i.op = 3'd0;
      return i;
   endfunction

   task automatic drive(input instr_t i, input logic fl);
      regwrite = i.rw; memread = i.mr; memwrite = i.mw; branch = i.br;
      memtoreg = i.m2r; regdst = i.rdst; alusrc = i.asrc;
      data1 = i.d1; data2 = i.d2; offset = i.off;
      regdest1 = i.rt; regdest2 = i.rd; aluop = i.op; flush = fl;
   endtask

   task automatic chk_bubble(input string tag);
      chk(tag, {59'd0, regwriteout, memreadout, memwriteout, memtoregout, branchtaken}, 64'd0);
   endtask

   task automatic chk_result(input instr_t i, input logic [W-1:0] exp);
      chk("aluresult", aluresult, exp);
      chk("storedata", storedata, i.d2);
      chk("destreg", destreg, i.rdst ? i.rd : i.rt);
      chk("ctl", {regwriteout, memreadout, memwriteout, memtoregout}, {i.rw, i.mr, i.mw, i.m2r});
      chk("zero", zero, exp == 0);
      chk("branchtaken", branchtaken, i.br && (exp == 0));
   endtask

   // Issue one instruction; fc selects the cycle (0 = issue cycle, c = BUSY cnt c-1)
   // in which flush is asserted, -1 for none. Inputs during BUSY are random junk.
   task automatic run_instr(input instr_t in, input int fc);
      logic [W-1:0] exp;
      int c, nstall;
      bit done;
      exp = ref_alu(in.op, in.d1, in.asrc ? in.off : in.d2);
      c = 0; nstall = 0; done = 0;
      while (!done) begin
         @(negedge clk);
         if (c == 0) drive(in, fc == 0);
         else drive(rand_instr(), fc == c);
         #1;
         if (fc == c) begin
            chk("stall_on_flush", stall, 0);
            @(posedge clk); #1;
            chk_bubble("flush_bubble");
            done = 1;
         end else if (in.op != 3'd6) begin
            chk("stall_single", stall, 0);
            @(posedge clk); #1;
            chk_result(in, exp);
            done = 1;
         end else if (stall) begin
            nstall++;
            @(posedge clk); #1;
            chk_bubble("mul_bubble");
            if (c > 100) begin
               chk("mul_timeout", 1, 0);
               done = 1;
            end
         end else begin
            chk("mul_stall_cycles", nstall, MC);
            @(posedge clk); #1;
            chk_result(in, exp);
            done = 1;
         end
         c++;
      end
   endtask

   instr_t t;
   int fc;

   initial begin
      rst_n = 1'b0;
      t = nop_instr();
      t.op = 3'd6; t.d1 = 16'h5; t.d2 = 16'h7;
      drive(t, 1'b0);
      #12;
      chk("reset_stall", stall, 0);
      chk("reset_outs", {aluresult, storedata, destreg, regwriteout, memreadout, memwriteout,
                         memtoregout, branchtaken, zero}, 64'd0);
      @(negedge clk); drive(nop_instr(), 1'b0);
      @(negedge clk); rst_n = 1'b1;

      // ADD 3+4 to rd=5
      t = nop_instr(); t.op = 3'd0; t.d1 = 16'h0003; t.d2 = 16'h0004;
      t.rw = 1; t.rdst = 1; t.rd = 4'd5; t.rt = 4'd2;
      run_instr(t, -1);
      // SUB equal operands with branch
      t = nop_instr(); t.op = 3'd1; t.d1 = 16'h1234; t.d2 = 16'h1234; t.br = 1;
      run_instr(t, -1);
      // MUL 0x12*0x34 then back-to-back issue
      t = nop_instr(); t.op = 3'd6; t.d1 = 16'h0012; t.d2 = 16'h0034; t.rw = 1;
      run_instr(t, -1);
      chk("mul_known", aluresult, 16'h03A8);
      t = nop_instr(); t.op = 3'd6; t.d1 = 16'h1234; t.asrc = 1; t.off = 16'h0010; t.rw = 1;
      run_instr(t, -1);
      chk("mul_wrap", aluresult, 16'h2340);
      t = nop_instr(); t.op = 3'd4; t.d1 = 16'hFFFF; t.d2 = 16'h0001; t.rw = 1;
      run_instr(t, -1);
      chk("slt_signed", aluresult, 16'h0001);
      // flush at cnt=5, then an ADD must issue normally
      t = nop_instr(); t.op = 3'd6; t.d1 = 16'h00FF; t.d2 = 16'h0003; t.rw = 1; t.mw = 1;
      run_instr(t, 6);
      t = nop_instr(); t.op = 3'd0; t.d1 = 16'h1111; t.d2 = 16'h2222; t.rw = 1; t.rdst = 1; t.rd = 4'd7;
      run_instr(t, -1);

      // async reset at cnt=8 of a MUL
      t = nop_instr(); t.op = 3'd6; t.d1 = 16'h0101; t.d2 = 16'h0202; t.rw = 1; t.rd = 4'd3; t.rdst = 1;
      for (int c = 0; c <= 9; c++) begin
         @(negedge clk); drive(t, 1'b0); #1;
         if (c < 9) @(posedge clk);
      end
      chk("pre_reset_stall", stall, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_stall", stall, 0);
      chk("async_reset_outs", {aluresult, storedata, destreg, regwriteout, memreadout, memwriteout,
                               memtoregout, branchtaken, zero}, 64'd0);
      @(negedge clk); drive(nop_instr(), 1'b0);
      @(negedge clk); rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk); #1;
         chk("post_reset_stall", stall, 0);
         @(posedge clk); #1;
         chk("post_reset_quiet", {regwriteout, aluresult}, 17'd0);
      end

      // randomized traffic
      for (int n = 0; n < 250; n++) begin
         t = rand_instr();
         fc = -1;
         if ($urandom_range(0, 9) == 0) fc = (t.op == 3'd6) ? int'($urandom_range(0, MC)) : 0;
         run_instr(t, fc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
